// File: rtl/magnitude_ctrl.sv
// Sobel magnitude sequencer: issues gx/gy pairs to the magnitude unit under
// credit control and packs the returned 4-bit pixels two per output byte.
module magnitude_ctrl #(
    parameter int PIXELS_PER_FRAME = 1024,
    parameter int CNT_W            = 11,
    parameter int PBUF_DEPTH       = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             frame_start,
    input  logic             conv_valid,
    input  logic [9:0]       conv_gx,
    input  logic [9:0]       conv_gy,
    output logic             conv_ready,
    output logic [9:0]       mag_gx,
    output logic [9:0]       mag_gy,
    output logic             mag_calc_done,
    input  logic [3:0]       mag_pixel,
    input  logic             mag_output_enable,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] pixel_count,
    output logic             err
);
    // state | meaning
    // IDLE  | waiting for frame_start
    // RUN   | accepting pairs and issuing them to the magnitude unit
    // DRAIN | all pairs issued; flushing pipeline, buffer and packer
    // DONE  | one-cycle frame completion pulse
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int PTR_W = $clog2(PBUF_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    state_t           state, state_nxt;
    logic [OCC_W-1:0] in_flight, buf_count;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [3:0]       pbuf [PBUF_DEPTH];
    logic             half_valid;
    logic [3:0]       half_nib;
    logic [OCC_W:0]   credit_used;

    logic start, accept, last_pair, mag_take, unexpected, ret_ok;
    logic out_free, pop, overflow, push, drained;

    assign start       = (state == IDLE) && frame_start;
    assign credit_used = {1'b0, in_flight} + {1'b0, buf_count};
    assign conv_ready  = (state == RUN)
                         && (credit_used < (OCC_W+1)'(PBUF_DEPTH))
                         && (pixel_count < CNT_W'(PIXELS_PER_FRAME));
    assign accept      = conv_valid && conv_ready;
    assign last_pair   = accept && (pixel_count == CNT_W'(PIXELS_PER_FRAME - 1));

    // Stale results arriving in IDLE (e.g. after a mid-frame reset) are ignored.
    assign mag_take    = mag_output_enable && (state != IDLE);
    assign unexpected  = mag_take && (in_flight == '0);
    assign ret_ok      = mag_take && (in_flight != '0);

    // The high-half pop never touches out_data, so only the second pop waits for the byte slot.
    assign out_free    = !out_valid || out_ready;
    assign pop         = (buf_count != '0) && (!half_valid || out_free);
    assign overflow    = ret_ok && (buf_count == OCC_W'(PBUF_DEPTH)) && !pop;
    assign push        = ret_ok && !overflow;

    assign drained     = (in_flight == '0) && (buf_count == '0) && !half_valid && !out_valid;
    assign busy        = (state == RUN) || (state == DRAIN);
    assign frame_done  = (state == DONE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = RUN;
            RUN:     if (last_pair)   state_nxt = DRAIN;
            DRAIN:   if (drained)     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mag_gx        <= '0;
            mag_gy        <= '0;
            mag_calc_done <= 1'b0;
            pixel_count   <= '0;
            in_flight     <= '0;
        end else begin
            mag_calc_done <= accept;
            if (accept) begin
                mag_gx <= conv_gx;
                mag_gy <= conv_gy;
            end
            if (start)       pixel_count <= '0;
            else if (accept) pixel_count <= pixel_count + CNT_W'(1);
            if (start) begin
                in_flight <= '0;
            end else begin
                case ({accept, ret_ok})
                    2'b10:   in_flight <= in_flight + OCC_W'(1);
                    2'b01:   in_flight <= in_flight - OCC_W'(1);
                    default: in_flight <= in_flight;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) pbuf[wr_ptr] <= mag_pixel;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            buf_count  <= '0;
            half_valid <= 1'b0;
            half_nib   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            err        <= 1'b0;
        end else if (start) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            buf_count  <= '0;
            half_valid <= 1'b0;
            half_nib   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            err        <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   buf_count <= buf_count + OCC_W'(1);
                2'b01:   buf_count <= buf_count - OCC_W'(1);
                default: buf_count <= buf_count;
            endcase
            if (unexpected || overflow) err <= 1'b1;

            if (out_valid && out_ready) out_valid <= 1'b0;
            if (pop) begin
                if (half_valid) begin
                    out_data   <= {half_nib, pbuf[rd_ptr]};
                    out_valid  <= 1'b1;
                    half_valid <= 1'b0;
                end else begin
                    half_nib   <= pbuf[rd_ptr];
                    half_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_magnitude_ctrl.sv
// Bench for magnitude_ctrl: a behavioural magnitude unit plus a frame-level
// model of the expected packed byte stream.
module tb_magnitude_ctrl;
    localparam int PPF   = 4;
    localparam int CNT_W = 3;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             n_rst = 1'b1;
    logic             frame_start = 1'b0;
    logic             conv_valid = 1'b0;
    logic [9:0]       conv_gx = '0;
    logic [9:0]       conv_gy = '0;
    logic             conv_ready;
    logic [9:0]       mag_gx, mag_gy;
    logic             mag_calc_done;
    logic [3:0]       mag_pixel;
    logic             mag_output_enable;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_ready = 1'b1;
    logic             busy, frame_done, err;
    logic [CNT_W-1:0] pixel_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    magnitude_ctrl #(.PIXELS_PER_FRAME(PPF), .CNT_W(CNT_W), .PBUF_DEPTH(DEPTH)) dut (
        .clk(clk), .n_rst(n_rst), .frame_start(frame_start),
        .conv_valid(conv_valid), .conv_gx(conv_gx), .conv_gy(conv_gy), .conv_ready(conv_ready),
        .mag_gx(mag_gx), .mag_gy(mag_gy), .mag_calc_done(mag_calc_done),
        .mag_pixel(mag_pixel), .mag_output_enable(mag_output_enable),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .frame_done(frame_done), .pixel_count(pixel_count), .err(err)
    );

    function automatic logic [3:0] mag_of(input logic [9:0] gx, input logic [9:0] gy);
        int ax, ay, s;
        ax = int'($signed(gx));
        ay = int'($signed(gy));
        if (ax < 0) ax = -ax;
        if (ay < 0) ay = -ay;
        s = (ax + ay) / 64;
        if (s > 15) s = 15;
        return 4'(s);
    endfunction

    // Magnitude unit model: result appears three edges after mag_calc_done is registered.
    logic [4:0] st1 = '0, st2 = '0, st3 = '0;
    logic       inject_oe = 1'b0;
    always @(posedge clk) begin
        st1 <= {mag_calc_done, mag_of(mag_gx, mag_gy)};
        st2 <= st1;
        st3 <= st2;
    end
    assign mag_output_enable = st3[4] | inject_oe;
    assign mag_pixel         = st3[3:0];

    logic [9:0] stim_gx[$];
    logic [9:0] stim_gy[$];
    logic [7:0] got_bytes[$];
    int         cyc = 0;
    int         acc_cnt = 0, acc_base = 0, fd_cnt = 0;
    int         a_cyc = -1, c_cyc = -1, o_cyc = -1, stall_viol = 0;
    logic [9:0] first_gx = '0;
    logic [7:0] stall_data = '0, prev_data = '0;
    bit         stall_seen = 0, prev_stall = 0, prev_busy = 0;
    logic       err_at_done = 0, busy_at_done = 0, prev_busy_at_done = 0;
    logic [CNT_W-1:0] pc_at_done = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (n_rst) begin
            if (conv_valid && conv_ready) begin
                acc_cnt = acc_cnt + 1;
                if (a_cyc < 0) a_cyc = cyc;
            end
            if (mag_calc_done && c_cyc < 0) begin
                c_cyc = cyc;
                first_gx = mag_gx;
            end
            if (mag_output_enable && o_cyc < 0) o_cyc = cyc;
            if (out_valid && out_ready) got_bytes.push_back(out_data);
            if (out_valid && !out_ready) begin
                if (prev_stall && out_data !== prev_data) stall_viol = stall_viol + 1;
                if (!stall_seen) begin
                    stall_seen = 1;
                    stall_data = out_data;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (frame_done) begin
                fd_cnt = fd_cnt + 1;
                err_at_done = err;
                busy_at_done = busy;
                prev_busy_at_done = prev_busy;
                pc_at_done = pixel_count;
            end
            prev_busy = busy;
        end
    end

    function automatic logic [7:0] exp_byte(input int i);
        return {mag_of(stim_gx[2*i], stim_gy[2*i]), mag_of(stim_gx[2*i+1], stim_gy[2*i+1])};
    endfunction

    // vmode: 0 valid held, 1 toggling, 2 random; rmode: 0 ready held, 1 random, 2 stalled 20 cycles
    task automatic drive_frame(input int vmode, input int rmode, input bit do_start,
                               input int restart_at, output bit timed_out);
        int idx, fd0;
        fd0 = fd_cnt;
        acc_base = acc_cnt;
        got_bytes.delete();
        a_cyc = -1; c_cyc = -1; o_cyc = -1;
        stall_viol = 0; stall_seen = 0;
        if (do_start) begin
            frame_start = 1'b1;
            @(posedge clk); #1;
            frame_start = 1'b0;
        end
        timed_out = 1'b1;
        for (int c = 0; c < 300; c++) begin
            idx = acc_cnt - acc_base;
            if (idx < stim_gx.size()) begin
                conv_gx = stim_gx[idx];
                conv_gy = stim_gy[idx];
            end
            case (vmode)
                0:       conv_valid = (idx < stim_gx.size());
                1:       conv_valid = (c % 2 == 0) && (idx < stim_gx.size());
                default: conv_valid = ($urandom_range(0, 1) == 1) && (idx < stim_gx.size());
            endcase
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 1) == 1);
                default: out_ready = (c >= 20);
            endcase
            frame_start = (c == restart_at);
            @(posedge clk); #1;
            if (fd_cnt != fd0) begin
                timed_out = 1'b0;
                break;
            end
        end
        conv_valid = 1'b0;
        frame_start = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic load_stream_stim();
        stim_gx = '{10'd64, 10'd0,   10'h3C0, 10'd100};
        stim_gy = '{10'd0,  10'h380, 10'd128, 10'd156};
    endtask

    task automatic test_reset();
        #2 n_rst = 1'b0;
        #2;
        checks++;
        if ({conv_ready, mag_gx, mag_gy, mag_calc_done, out_valid, out_data, busy,
             frame_done, pixel_count, err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b ready=%b out_valid=%b pc=%0d err=%b, required all zero",
                     busy, conv_ready, out_valid, pixel_count, err);
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || conv_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_hold: busy=%b conv_ready=%b, required 0 0", busy, conv_ready);
        end
    endtask

    task automatic test_streaming();
        bit to;
        int fd0;
        load_stream_stim();
        fd0 = fd_cnt;
        drive_frame(0, 0, 1, -1, to);
        checks++;
        if (to) begin failures++; $display("FAIL stream_timeout: frame_done not seen"); end
        checks++;
        if (got_bytes.size() != 2) begin
            failures++; $display("FAIL stream_count: got %0d bytes, required 2", got_bytes.size());
        end
        checks++;
        if (got_bytes.size() < 1 || got_bytes[0] !== 8'h12) begin
            failures++; $display("FAIL stream_byte0: got %h, required 12", (got_bytes.size() > 0) ? got_bytes[0] : 8'hxx);
        end
        checks++;
        if (got_bytes.size() < 2 || got_bytes[1] !== 8'h34) begin
            failures++; $display("FAIL stream_byte1: got %h, required 34", (got_bytes.size() > 1) ? got_bytes[1] : 8'hxx);
        end
        checks++;
        if (c_cyc != a_cyc + 1 || first_gx !== 10'd64) begin
            failures++; $display("FAIL stream_calc_done: delay=%0d gx=%0d, required 1 and 64", c_cyc - a_cyc, first_gx);
        end
        checks++;
        if (o_cyc != a_cyc + 4) begin
            failures++; $display("FAIL stream_oe_latency: got %0d cycles, required 4", o_cyc - a_cyc);
        end
        checks++;
        if (fd_cnt - fd0 != 1) begin
            failures++; $display("FAIL stream_frame_done: got %0d pulse cycles, required 1", fd_cnt - fd0);
        end
        checks++;
        if (prev_busy_at_done !== 1'b1 || busy_at_done !== 1'b0) begin
            failures++; $display("FAIL stream_busy_fall: before=%b at_done=%b, required 1 0", prev_busy_at_done, busy_at_done);
        end
        checks++;
        if (pc_at_done !== CNT_W'(PPF) || err_at_done !== 1'b0) begin
            failures++; $display("FAIL stream_count_err: pc=%0d err=%b, required %0d 0", pc_at_done, err_at_done, PPF);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        load_stream_stim();
        drive_frame(0, 2, 1, -1, to);
        checks++;
        if (to) begin failures++; $display("FAIL bp_timeout: frame_done not seen"); end
        checks++;
        if (!stall_seen || stall_data !== 8'h12 || stall_viol != 0) begin
            failures++; $display("FAIL bp_stable: seen=%b data=%h changes=%0d, required 1 12 0", stall_seen, stall_data, stall_viol);
        end
        checks++;
        if (acc_cnt - acc_base != PPF || err_at_done !== 1'b0) begin
            failures++; $display("FAIL bp_accept_err: accepts=%0d err=%b, required %0d 0", acc_cnt - acc_base, err_at_done, PPF);
        end
        for (int i = 0; i < PPF / 2; i++) begin
            checks++;
            if (got_bytes.size() <= i || got_bytes[i] !== exp_byte(i)) begin
                failures++; $display("FAIL bp_byte%0d: got %h, required %h", i, (got_bytes.size() > i) ? got_bytes[i] : 8'hxx, exp_byte(i));
            end
        end
    endtask

    task automatic test_handshake_corner();
        bit to;
        load_stream_stim();
        drive_frame(1, 1, 1, -1, to);
        checks++;
        if (to) begin failures++; $display("FAIL hs_timeout: frame_done not seen"); end
        checks++;
        if (got_bytes.size() != 2 || got_bytes[0] !== 8'h12 || got_bytes[1] !== 8'h34) begin
            failures++; $display("FAIL hs_bytes: got %0d bytes first=%h, required 12 34", got_bytes.size(), (got_bytes.size() > 0) ? got_bytes[0] : 8'hxx);
        end
        checks++;
        if (pc_at_done !== CNT_W'(PPF)) begin
            failures++; $display("FAIL hs_pixel_count: got %0d, required %0d", pc_at_done, PPF);
        end
    endtask

    task automatic test_protocol();
        bit to;
        load_stream_stim();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        inject_oe = 1'b1;
        @(posedge clk); #1;
        inject_oe = 1'b0;
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL proto_err_set: err=%b, required 1", err); end
        drive_frame(0, 0, 0, -1, to);
        checks++;
        if (to || err_at_done !== 1'b1) begin
            failures++; $display("FAIL proto_err_sticky: timeout=%b err_at_done=%b, required 0 1", to, err_at_done);
        end
        checks++;
        if (got_bytes.size() != 2 || got_bytes[0] !== 8'h12 || got_bytes[1] !== 8'h34) begin
            failures++; $display("FAIL proto_bytes: got %0d bytes first=%h, required 12 34", got_bytes.size(), (got_bytes.size() > 0) ? got_bytes[0] : 8'hxx);
        end
        drive_frame(0, 0, 1, -1, to);
        checks++;
        if (to || err_at_done !== 1'b0) begin
            failures++; $display("FAIL proto_err_clear: timeout=%b err_at_done=%b, required 0 0", to, err_at_done);
        end
    endtask

    task automatic test_ignored_start();
        bit to;
        int fd0;
        load_stream_stim();
        fd0 = fd_cnt;
        drive_frame(1, 0, 1, 2, to);
        checks++;
        if (to) begin failures++; $display("FAIL ign_timeout: frame_done not seen"); end
        checks++;
        if (acc_cnt - acc_base != PPF || pc_at_done !== CNT_W'(PPF) || fd_cnt - fd0 != 1) begin
            failures++; $display("FAIL ign_counts: accepts=%0d pc=%0d done=%0d, required %0d %0d 1", acc_cnt - acc_base, pc_at_done, fd_cnt - fd0, PPF, PPF);
        end
        checks++;
        if (got_bytes.size() != 2 || got_bytes[0] !== 8'h12 || got_bytes[1] !== 8'h34) begin
            failures++; $display("FAIL ign_bytes: got %0d bytes first=%h, required 12 34", got_bytes.size(), (got_bytes.size() > 0) ? got_bytes[0] : 8'hxx);
        end
    endtask

    task automatic test_reset_mid_run();
        bit to;
        int idx;
        load_stream_stim();
        acc_base = acc_cnt;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            idx = acc_cnt - acc_base;
            conv_valid = 1'b1;
            conv_gx = stim_gx[idx];
            conv_gy = stim_gy[idx];
            @(posedge clk); #1;
        end
        conv_valid = 1'b0;
        n_rst = 1'b0;
        #2;
        checks++;
        if ({conv_ready, mag_gx, mag_gy, mag_calc_done, out_valid, out_data, busy,
             frame_done, pixel_count, err} !== '0) begin
            failures++;
            $display("FAIL midrun_reset: busy=%b pc=%0d calc=%b err=%b, required all zero", busy, pixel_count, mag_calc_done, err);
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL midrun_stale: err=%b busy=%b, required 0 0", err, busy);
        end
        stim_gx.delete(); stim_gy.delete();
        for (int i = 0; i < PPF; i++) begin
            stim_gx.push_back(10'($urandom));
            stim_gy.push_back(10'($urandom));
        end
        drive_frame(2, 1, 1, -1, to);
        checks++;
        if (to || err_at_done !== 1'b0 || got_bytes.size() != PPF / 2) begin
            failures++; $display("FAIL midrun_next: timeout=%b err=%b bytes=%0d, required 0 0 %0d", to, err_at_done, got_bytes.size(), PPF / 2);
        end
        for (int i = 0; i < PPF / 2; i++) begin
            checks++;
            if (got_bytes.size() <= i || got_bytes[i] !== exp_byte(i)) begin
                failures++; $display("FAIL midrun_byte%0d: got %h, required %h", i, (got_bytes.size() > i) ? got_bytes[i] : 8'hxx, exp_byte(i));
            end
        end
    endtask

    task automatic test_random();
        bit to;
        for (int f = 0; f < 20; f++) begin
            stim_gx.delete(); stim_gy.delete();
            for (int i = 0; i < PPF; i++) begin
                stim_gx.push_back(10'($urandom));
                stim_gy.push_back(10'($urandom));
            end
            drive_frame(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1, -1, to);
            checks++;
            if (to || got_bytes.size() != PPF / 2) begin
                failures++; $display("FAIL rand%0d_count: timeout=%b bytes=%0d, required 0 %0d", f, to, got_bytes.size(), PPF / 2);
            end
            for (int i = 0; i < PPF / 2; i++) begin
                checks++;
                if (got_bytes.size() <= i || got_bytes[i] !== exp_byte(i)) begin
                    failures++; $display("FAIL rand%0d_byte%0d: got %h, required %h", f, i, (got_bytes.size() > i) ? got_bytes[i] : 8'hxx, exp_byte(i));
                end
            end
            checks++;
            if (err_at_done !== 1'b0 || pc_at_done !== CNT_W'(PPF) || stall_viol != 0) begin
                failures++; $display("FAIL rand%0d_status: err=%b pc=%0d changes=%0d, required 0 %0d 0", f, err_at_done, pc_at_done, stall_viol, PPF);
            end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_handshake_corner();
        test_protocol();
        test_ignored_start();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
